// File: rtl/f_arb_pkg.sv
// Shared types and the round-robin search helper for the f_mult arbiter.
// Tags are sized for the largest supported requester count (8).
package f_arb_pkg;

  localparam int unsigned MAX_REQ = 8;
  localparam int unsigned TAG_W   = $clog2(MAX_REQ);

  typedef logic [TAG_W-1:0] tag_t;

  typedef struct packed {
    logic found;
    tag_t idx;
  } pick_t;

  // First set bit of vld[n-1:0], searching upward from (ptr+1) mod n with wrap.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] vld, input tag_t ptr,
                                    input int unsigned n);
    pick_t       p;
    int unsigned k;
    p = '0;
    for (int unsigned i = 1; i <= MAX_REQ; i++) begin
      k = (32'(ptr) + i) % n;
      if (i <= n && !p.found && vld[tag_t'(k)]) begin
        p.found = 1'b1;
        p.idx   = tag_t'(k);
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/f_arb_tag_fifo.sv
// In-order FIFO of requester tags for operations issued to the shared multiplier.
// Push is ignored when full and pop is ignored when empty.
module f_arb_tag_fifo
  import f_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = TAG_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_tag,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_tag,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_q, rd_q;
  logic [CntW-1:0]  cnt_q;
  logic             do_push, do_pop;

  assign full     = (cnt_q == CntW'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign head_tag = mem_q[rd_q];
  assign count    = cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_tag;
  end

endmodule

// File: rtl/f_mult_arbiter.sv
// Round-robin sharing of one pipelined f_mult between N_REQ requesters, results routed by tag.
// Optional per-requester grant counters: define F_MULT_ARBITER_STATS_EN.
module f_mult_arbiter
  import f_arb_pkg::*;
#(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned MAX_INFLIGHT = 8,
  parameter int unsigned FLEN         = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_vld,
  output logic [N_REQ-1:0]        req_rdy,
  input  logic [N_REQ*FLEN-1:0]   req_a,
  input  logic [N_REQ*FLEN-1:0]   req_b,
  output logic [N_REQ-1:0]        rsp_vld,
  output logic [FLEN-1:0]         rsp_res,
  output logic                    rsp_err,
  output logic [FLEN-1:0]         mult_a,
  output logic [FLEN-1:0]         mult_b,
  output logic                    mult_up_valid,
  input  logic [FLEN-1:0]         mult_res,
  input  logic                    mult_down_valid,
  input  logic                    mult_error,
  output logic                    busy,
  output logic                    proto_err
`ifdef F_MULT_ARBITER_STATS_EN
  ,
  output logic [N_REQ*16-1:0]     grant_cnt
`endif
);

  localparam int unsigned CntW = $clog2(MAX_INFLIGHT + 1);

  logic [MAX_REQ-1:0] vld_ext;
  pick_t              pick;
  tag_t               ptr_q, head_tag;
  logic               grant, full, empty, pop;
  logic [CntW-1:0]    count;
  logic [N_REQ-1:0]   rsp_vld_d, rsp_vld_q;
  logic [FLEN-1:0]    rsp_res_q;
  logic               rsp_err_q, proto_err_q;

  always_comb begin
    vld_ext              = '0;
    vld_ext[N_REQ-1:0]   = req_vld;
  end

  assign pick = rr_pick(vld_ext, ptr_q, N_REQ);
  // Gating with rst keeps the issue side quiet while reset is held.
  assign grant = rst & pick.found & ~full;

  always_comb begin
    req_rdy = '0;
    mult_a  = '0;
    mult_b  = '0;
    if (grant) begin
      for (int unsigned i = 0; i < N_REQ; i++) req_rdy[i] = (pick.idx == tag_t'(i));
      mult_a = req_a[32'(pick.idx)*FLEN +: FLEN];
      mult_b = req_b[32'(pick.idx)*FLEN +: FLEN];
    end
  end

  assign mult_up_valid = grant;
  assign pop           = mult_down_valid & ~empty;
  assign busy          = (count != '0);

  f_arb_tag_fifo #(
    .DEPTH (MAX_INFLIGHT),
    .WIDTH (TAG_W)
  ) u_tag_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (grant),
    .push_tag (pick.idx),
    .pop      (pop),
    .head_tag (head_tag),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  always_comb begin
    rsp_vld_d = '0;
    if (pop) begin
      for (int unsigned i = 0; i < N_REQ; i++) rsp_vld_d[i] = (head_tag == tag_t'(i));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q       <= tag_t'(N_REQ - 1);
      rsp_vld_q   <= '0;
      rsp_res_q   <= '0;
      rsp_err_q   <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      if (grant) ptr_q <= pick.idx;
      rsp_vld_q <= rsp_vld_d;
      if (pop) begin
        rsp_res_q <= mult_res;
        rsp_err_q <= mult_error;
      end
      // A result with nothing outstanding means the multiplier and arbiter disagree.
      if (mult_down_valid && empty) proto_err_q <= 1'b1;
    end
  end

  assign rsp_vld   = rsp_vld_q;
  assign rsp_res   = rsp_res_q;
  assign rsp_err   = rsp_err_q;
  assign proto_err = proto_err_q;

`ifdef F_MULT_ARBITER_STATS_EN
  logic [15:0] cnt_q [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_stats
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt_q[g] <= '0;
      end else if (req_rdy[g] && cnt_q[g] != 16'hFFFF) begin
        cnt_q[g] <= cnt_q[g] + 16'd1;
      end
    end
    assign grant_cnt[g*16 +: 16] = cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_f_mult_arbiter.sv
// Bench for f_mult_arbiter: random and directed requesters, a latency-L multiplier model,
// a round-robin reference and an in-order response scoreboard.
module tb_f_mult_arbiter;

  localparam int unsigned NReq   = 4;
  localparam int unsigned MaxInf = 8;
  localparam int unsigned Flen   = 64;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NReq-1:0]        req_vld, req_rdy, rsp_vld;
  logic [NReq*Flen-1:0]   req_a, req_b;
  logic [Flen-1:0]        rsp_res, mult_a, mult_b, mult_res;
  logic                   rsp_err, mult_up_valid, mult_down_valid, mult_error, busy, proto_err;
`ifdef F_MULT_ARBITER_STATS_EN
  logic [NReq*16-1:0]     grant_cnt;
`endif

  f_mult_arbiter #(
    .N_REQ        (NReq),
    .MAX_INFLIGHT (MaxInf),
    .FLEN         (Flen)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_vld         (req_vld),
    .req_rdy         (req_rdy),
    .req_a           (req_a),
    .req_b           (req_b),
    .rsp_vld         (rsp_vld),
    .rsp_res         (rsp_res),
    .rsp_err         (rsp_err),
    .mult_a          (mult_a),
    .mult_b          (mult_b),
    .mult_up_valid   (mult_up_valid),
    .mult_res        (mult_res),
    .mult_down_valid (mult_down_valid),
    .mult_error      (mult_error),
    .busy            (busy),
    .proto_err       (proto_err)
`ifdef F_MULT_ARBITER_STATS_EN
    ,
    .grant_cnt       (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [63:0] res;
    logic        err;
    int          due;
  } exp_t;

  typedef struct {
    logic [63:0] res;
    logic        err;
    int          due;
  } pipe_t;

  exp_t        exp_q[$];
  pipe_t       pipe_q[$];
  int          grant_log[$];

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lat = 4;
  int          occ = 0;
  int          last_g = NReq - 1;
  int          n_rsp = 0;
  int          g;
  int          gcount [NReq];
  bit          pend [NReq];
  bit          gflag [NReq];
  bit          inject_dv = 1'b0;
  logic [63:0] a_val [NReq];
  logic [63:0] b_val [NReq];
  logic [63:0] last_res = '0;
  logic        last_err = 1'b0;
  logic [63:0] obs_res = '0;
  logic [63:0] obs_vld = '0;
  logic [63:0] obs_err = '0;
  logic [64:0] prod;
  exp_t        e;

  logic [63:0] tab [8] = '{64'h4000000000000000, 64'h4008000000000000, 64'h3FF0000000000000,
                           64'h3FE0000000000000, 64'hBFF8000000000000, 64'h4024000000000000,
                           64'h7FF0000000000000, 64'h0000000000000000};

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Multiplier reference: IEEE double product; error on an Inf/NaN operand.
  function automatic logic [64:0] fmul(input logic [63:0] a, input logic [63:0] b);
    logic err;
    err = (&a[62:52]) | (&b[62:52]);
    return {err, $realtobits($bitstoreal(a) * $bitstoreal(b))};
  endfunction

  // f_mult model: result appears lat cycles after up_valid; shares the arbiter reset.
  always @(negedge clk) begin
    #1;
    mult_down_valid = 1'b0;
    mult_res        = {$urandom, $urandom};
    mult_error      = 1'($urandom_range(1));
    if (!rst) begin
      pipe_q.delete();
    end else if (pipe_q.size() > 0 && pipe_q[0].due == cyc + 1) begin
      mult_down_valid = 1'b1;
      mult_res        = pipe_q[0].res;
      mult_error      = pipe_q[0].err;
      void'(pipe_q.pop_front());
    end
    if (inject_dv) begin
      mult_down_valid = 1'b1;
      inject_dv       = 1'b0;
    end
  end

  // Issue side: round-robin reference decides the grant for the coming edge.
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      chk("rdy_in_reset", 64'(req_rdy), 64'd0);
      chk("upv_in_reset", 64'(mult_up_valid), 64'd0);
      chk("busy_in_reset", 64'(busy), 64'd0);
      chk("rsp_vld_in_reset", 64'(rsp_vld), 64'd0);
      chk("rsp_res_in_reset", rsp_res, 64'd0);
      chk("proto_err_in_reset", 64'(proto_err), 64'd0);
      occ      = 0;
      last_g   = NReq - 1;
      last_res = '0;
      last_err = 1'b0;
      for (int i = 0; i < NReq; i++) gcount[i] = 0;
    end else begin
      g = -1;
      if (occ < MaxInf) begin
        for (int k = 1; k <= NReq; k++) begin
          if (g < 0 && req_vld[(last_g + k) % NReq]) g = (last_g + k) % NReq;
        end
      end
      chk("req_rdy", 64'(req_rdy), (g >= 0) ? (64'd1 << g) : 64'd0);
      chk("up_valid", 64'(mult_up_valid), 64'(g >= 0));
      chk("busy", 64'(busy), 64'(occ != 0));
      if (mult_up_valid) begin
        prod = fmul(mult_a, mult_b);
        pipe_q.push_back('{prod[63:0], prod[64], cyc + 1 + lat});
      end
      if (g >= 0) begin
        chk("mult_a", mult_a, a_val[g]);
        chk("mult_b", mult_b, b_val[g]);
        prod = fmul(a_val[g], b_val[g]);
        exp_q.push_back('{g, prod[63:0], prod[64], cyc + 1 + lat});
        gflag[g] = 1'b1;
        last_g   = g;
        grant_log.push_back(g);
        gcount[g]++;
      end
      occ = occ + ((g >= 0) ? 1 : 0) - ((mult_down_valid && occ > 0) ? 1 : 0);
    end
  end

  // Response monitor: pops the scoreboard whenever the DUT presents a result.
  always @(negedge clk) begin
    #2;
    if (rst) begin
      if (rsp_vld != '0) begin
        obs_vld = 64'(rsp_vld);
        obs_res = rsp_res;
        obs_err = 64'(rsp_err);
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 64'(rsp_vld), 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_vld", 64'(rsp_vld), 64'd1 << e.idx);
          chk("rsp_res", rsp_res, e.res);
          chk("rsp_err", 64'(rsp_err), 64'(e.err));
          chk("rsp_time", 64'(cyc), 64'(e.due));
          last_res = e.res;
          last_err = e.err;
          n_rsp++;
        end
      end else begin
        chk("rsp_res_hold", rsp_res, last_res);
        chk("rsp_err_hold", 64'(rsp_err), 64'(last_err));
        if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
          chk("rsp_timeout", 64'(cyc), 64'(exp_q[0].due));
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic drive();
    for (int i = 0; i < NReq; i++) begin
      req_vld[i]              = pend[i];
      req_a[i*Flen +: Flen]   = a_val[i];
      req_b[i*Flen +: Flen]   = b_val[i];
    end
  endtask

  // One requester cycle: retire granted ops, optionally raise new random ones.
  task automatic step(input logic [NReq-1:0] gen, input int rate);
    @(negedge clk);
    for (int i = 0; i < NReq; i++) begin
      if (gflag[i]) begin
        pend[i]  = 1'b0;
        gflag[i] = 1'b0;
      end
      if (!pend[i] && gen[i] && $urandom_range(99) < rate) begin
        a_val[i] = tab[$urandom_range(7)];
        b_val[i] = tab[$urandom_range(7)];
        pend[i]  = 1'b1;
      end
    end
    drive();
    #3;
  endtask

  task automatic load(input int i, input logic [63:0] a, input logic [63:0] b);
    a_val[i] = a;
    b_val[i] = b;
    pend[i]  = 1'b1;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || pend.sum() != 0) && n < budget) begin
      step('0, 0);
      n++;
    end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NReq; i++) begin
      pend[i]  = 1'b0;
      gflag[i] = 1'b0;
    end
    exp_q.delete();
    drive();
    req_vld = '1;
    @(negedge clk);
    rst = 1'b1;
    drive();
    #3;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst             = 1'b0;
    req_vld         = '0;
    req_a           = '0;
    req_b           = '0;
    mult_down_valid = 1'b0;
    mult_res        = '0;
    mult_error      = 1'b0;
    for (int i = 0; i < NReq; i++) begin
      pend[i]   = 1'b0;
      gflag[i]  = 1'b0;
      a_val[i]  = '0;
      b_val[i]  = '0;
      gcount[i] = 0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #3;

    // Single op: 2.0 * 3.0 on requester 1, L = 4.
    lat = 4;
    load(1, 64'h4000000000000000, 64'h4008000000000000);
    step('0, 0);
    drain(50);
    chk("single_count", 64'(n_rsp), 64'd1);
    chk("single_vld", obs_vld, 64'b0010);
    chk("single_res", obs_res, 64'h4018000000000000);
    chk("single_err", obs_err, 64'd0);

    // Round-robin from reset with all requesters busy.
    do_reset();
    grant_log.delete();
    repeat (8) step('1, 100);
    drain(100);
    for (int i = 0; i < 8; i++) chk("rr_order", 64'(grant_log[i]), 64'(i % NReq));

    // Full stall: latency longer than the tag FIFO depth.
    lat = 12;
    repeat (40) step(4'b0001, 100);
    drain(100);

    // Error routing from requester 2.
    lat = 4;
    load(2, 64'h7FF0000000000000, 64'h4000000000000000);
    step('0, 0);
    drain(50);
    chk("err_vld", obs_vld, 64'b0100);
    chk("err_flag", obs_err, 64'd1);

    // Random traffic at two latencies.
    lat = 3;
    repeat (300) step('1, 50);
    drain(100);
    lat = 1;
    repeat (200) step('1, 70);
    drain(100);

    // Reset with three operations in flight.
    lat = 8;
    load(0, tab[0], tab[1]);
    load(1, tab[2], tab[3]);
    load(2, tab[4], tab[5]);
    repeat (3) step('0, 0);
    do_reset();
    base = n_rsp;
    repeat (20) step('0, 0);
    chk("no_stale_rsp", 64'(n_rsp), 64'(base));
    lat = 4;
    load(1, 64'h4000000000000000, 64'h4008000000000000);
    step('0, 0);
    drain(50);
    chk("post_reset_count", 64'(n_rsp), 64'(base + 1));
    chk("post_reset_res", obs_res, 64'h4018000000000000);
    chk("post_reset_vld", obs_vld, 64'b0010);

`ifdef F_MULT_ARBITER_STATS_EN
    for (int i = 0; i < NReq; i++) chk("grant_cnt", 64'(grant_cnt[i*16 +: 16]), 64'(gcount[i]));
`endif

    // Protocol error: result with nothing outstanding.
    chk("proto_err_clear", 64'(proto_err), 64'd0);
    base = n_rsp;
    inject_dv = 1'b1;
    step('0, 0);
    chk("proto_err_not_yet", 64'(proto_err), 64'd0);
    step('0, 0);
    chk("proto_err_set", 64'(proto_err), 64'd1);
    repeat (5) step('0, 0);
    chk("proto_err_sticky", 64'(proto_err), 64'd1);
    chk("proto_no_rsp", 64'(n_rsp), 64'(base));
    load(3, tab[5], tab[0]);
    step('0, 0);
    drain(50);
    chk("proto_after_op", 64'(n_rsp), 64'(base + 1));
    chk("proto_err_still", 64'(proto_err), 64'd1);

    do_reset();
    step('0, 0);
    chk("proto_err_cleared", 64'(proto_err), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
